// File: rtl/nibble_packer_pkg.sv
// Shared widths and types for the nibble packer datapath.
// One FIFO entry is a packed word plus the count of valid nibbles in it.
package nibble_packer_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned NIBS   = 4;
    localparam int unsigned WORD_W = NIB_W * NIBS;
    localparam int unsigned CNT_W  = $clog2(NIBS);
    localparam int unsigned NCNT_W = 3;

    typedef logic [NIB_W-1:0]  nib_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t             data;
        logic [NCNT_W-1:0] nibs;
    } entry_t;

endpackage

// File: rtl/nibble_packer_fifo.sv
// Show-ahead synchronous FIFO of packed entries.
// The head is registered and holds its last value while the FIFO is empty.
module nibble_fifo
    import nibble_packer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  entry_t           i_push_data,
    input  logic             i_pop,
    output entry_t           o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr;
    logic [PTR_W-1:0]   r_rd;
    logic [LVL_W-1:0]   r_count;
    entry_t             r_head;
    logic               r_full;
    logic               r_empty;

    logic               w_push;
    logic               w_pop;
    logic [PTR_W-1:0]   w_rd_nxt;
    logic [LVL_W-1:0]   w_count_nxt;
    logic [LVL_W-1:0]   w_after_pop;
    entry_t             w_head_nxt;

    // Next pointer/occupancy, and which entry becomes the head after this edge.
    always_comb begin
        w_push      = i_push && !r_full;
        w_pop       = i_pop && !r_empty;
        w_rd_nxt    = r_rd + PTR_W'(w_pop);
        w_after_pop = r_count - LVL_W'(w_pop);
        w_count_nxt = w_after_pop + LVL_W'(w_push);
        w_head_nxt  = r_head;
        if (w_count_nxt != '0) begin
            if (w_after_pop == '0) begin
                w_head_nxt = i_push_data;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wr    <= r_wr + PTR_W'(w_push);
            r_rd    <= w_rd_nxt;
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_full  <= (w_count_nxt == LVL_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_head  = r_head;
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_level = r_count;

endmodule

// File: rtl/nibble_packer.sv
// Packs qualified nibbles LSB-first into words, with early close on in_last,
// and buffers completed words in a show-ahead FIFO drained over valid/ready.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [NIB_W-1:0]  in_nib,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [2:0]        out_nibs,
    input  logic              out_ready,
    output logic [2:0]        level,
    output logic              overflow
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    word_t              r_pack;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic               w_full;
    logic               w_empty;
    logic [LVL_W-1:0]   w_level;
    entry_t             w_head;
    logic               w_acc;
    logic               w_done;
    word_t              w_word;
    entry_t             w_entry;

    // Merge the incoming nibble into its slot; upper slots are still zero.
    always_comb begin
        w_acc   = in_valid && !w_full;
        w_done  = w_acc && ((r_cnt == CNT_W'(NIBS - 1)) || in_last);
        w_word  = r_pack;
        w_word[NIB_W*r_cnt +: NIB_W] = in_nib;
        w_entry = '{data: w_word, nibs: NCNT_W'(r_cnt) + NCNT_W'(1)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pack <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_acc) begin
                if (w_done) begin
                    r_pack <= '0;
                    r_cnt  <= '0;
                end else begin
                    r_pack <= w_word;
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
            end
            // Dropped nibble: sticky until reset.
            if (in_valid && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    nibble_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_done),
        .i_push_data (w_entry),
        .i_pop       (out_ready),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level)
    );

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = w_head.data;
    assign out_nibs  = w_head.nibs;
    assign level     = 3'(w_level);
    assign overflow  = r_ovf;

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Downstream consumer of the 4-bit priority-mux result (g) in the nibble datapath.
- Captures qualified nibbles, packs four of them LSB-first into a 16-bit word, and buffers completed words in a small show-ahead FIFO.
- Drains words over a valid/ready interface to the next stage (bus or serial transmitter).
- Supports early word close (in_last) and flags dropped input.

Parameters:
- NIB_W, 4, nibble width; must match the mux output width.
- NIBS, 4, nibbles per word; word width = NIB_W*NIBS = 16.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  in_nib is valid this cycle.
- in_nib  in  NIB_W  nibble from the mux output g.
- in_last  in  1  with in_valid: this nibble closes the current word.
- in_ready  out  1  packer can accept a nibble.
- out_valid  out  1  FIFO head is valid.
- out_data  out  NIB_W*NIBS  FIFO head word.
- out_nibs  out  3  number of valid nibbles in out_data (1..4).
- out_ready  in  1  consumer accepts the head word.
- level  out  3  FIFO occupancy (0..DEPTH).
- overflow  out  1  sticky; set when a nibble was dropped.

Behaviour:
- Reset (synchronous, active-high): pack count=0, pack register=0, FIFO empty, level=0, out_valid=0, out_data=0, out_nibs=0, overflow=0.
- Handshakes:
  - Input accept = in_valid && in_ready.
  - Output pop = out_valid && out_ready.
  - in_ready = !full, where full is level==DEPTH. It is registered-derived and has no combinational path from out_ready.
- Packing:
  - An accepted nibble is written to bits [NIB_W*cnt +: NIB_W] of the pack register, and cnt increments.
  - A word completes when (cnt==NIBS-1) or in_last on an accepted nibble.
  - On completion: push {nibble merged into pack register, unused upper nibbles forced 0} with nibs=cnt+1 into the FIFO, then clear the pack register and set cnt=0 on the same edge.
- in_last with cnt==NIBS-1 is an ordinary full word (nibs=4). in_last is ignored when in_valid=0.
- Latency: completing nibble at edge N puts the word on out_data with out_valid=1 from after edge N (i.e. one cycle after presentation), when the FIFO was empty.
- FIFO:
  - Show-ahead: out_data/out_nibs always reflect the head entry. When empty they hold their last value and out_valid=0.
  - Push and pop on the same edge: level unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
- Full:
  - in_ready=0 for all nibbles, including non-completing ones, which keeps the behaviour simple and deterministic.
  - A pop while full raises in_ready the next cycle, not in the same cycle.
- Overflow:
  - in_valid && !in_ready sets overflow=1 on that edge. The nibble is discarded, cnt is unchanged, and in_last on it is ignored.
  - overflow is cleared only by reset.
- Reset mid-word discards the partial word. Reset with a non-empty FIFO discards all entries.
- level increments on push-only, decrements on pop-only, and never exceeds DEPTH or goes below 0.

Decomposition:
- Shared package holds:
  - NIB_W, NIBS, WORD_W = NIB_W*NIBS.
  - Typedef nib_t [NIB_W-1:0] and word_t [WORD_W-1:0].
  - Typedef entry_t = {word_t data, logic [2:0] nibs}.
- One sub-module, nibble_fifo:
  - Generic show-ahead synchronous FIFO of entry_t, DEPTH entries.
  - Ports: push/pop/full/empty/level.
- nibble_packer holds the pack register, the count, the overflow flag, and one nibble_fifo instance.

Test Plan:
- Reset then a single word: nibbles 1,2,3,4 on consecutive cycles with out_ready=1 -> one cycle after the 4th nibble, out_valid=1, out_data=16'h4321, out_nibs=4; popped next edge, level returns to 0.
- Early close: nibbles A,B with in_last on B -> out_data=16'h00BA, out_nibs=2; the next nibbles C,D,E,F give 16'hFEDC.
- Backpressure: out_ready=0, send 16 nibbles 0..F -> level=4, in_ready=0. A 17th nibble 5 -> overflow=1 and level stays 4. Then out_ready=1 -> words 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC appear in order.
- Simultaneous push/pop: level=2 and out_ready=1 while the 4th nibble completes a word -> level stays 2 and order is preserved.
- Reset mid-operation: after nibbles 7,8 plus one queued word, assert reset for 1 cycle -> level=0, out_valid=0, overflow=0. Then nibbles 1,2,3,4 -> 16'h4321 with no residue of 7 or 8.
- Gapped input: nibbles 9, idle, idle, A, idle, B, C -> single word 16'hCBA9; no word is pushed during idle cycles.
